// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from a raw hs/vs pair: measures line and frame
// lengths, locks after consecutive clean frames and flags timing violations.
module vga_sync_decoder #(
    parameter int LINE        = 800,
    parameter int SCREEN      = 525,
    parameter int H_OFS       = 144,
    parameter int V_OFS       = 35,
    parameter int H_ACT       = 640,
    parameter int V_ACT       = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pix_stb,
    input  logic       i_hs,
    input  logic       i_vs,
    output logic [9:0] o_x,
    output logic [8:0] o_y,
    output logic       o_active,
    output logic       o_locked,
    output logic       o_frame_start,
    output logic       o_err,
    output logic [9:0] o_line_len,
    output logic [9:0] o_frame_lines
);

    localparam logic [9:0] CNT_MAX  = 10'd1023;
    localparam logic [9:0] LINE_W   = 10'(LINE);
    localparam logic [9:0] SCREEN_W = 10'(SCREEN);
    localparam logic [9:0] H_LO     = 10'(H_OFS);
    localparam logic [9:0] H_HI     = 10'(H_OFS + H_ACT);
    localparam logic [9:0] V_LO     = 10'(V_OFS);
    localparam logic [9:0] V_HI     = 10'(V_OFS + V_ACT);
    localparam logic [1:0] LOCK_W   = 2'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t     state_r;
    logic [1:0] good_r;
    logic       frame_bad_r;
    logic       hs_q_r;
    logic       vs_q_r;
    logic [9:0] h_cnt_r;
    logic [9:0] v_cnt_r;

    logic       hs_edge_s;
    logic       vs_edge_s;
    logic [9:0] line_meas_s;
    logic [9:0] frame_meas_s;
    logic [9:0] h_nxt_s;
    logic [9:0] v_nxt_s;
    logic       viol_s;
    logic       frame_ok_s;
    logic [1:0] good_inc_s;
    logic       locked_nxt_s;
    logic       active_nxt_s;
    logic [9:0] x_nxt_s;
    logic [9:0] y_full_s;

    // Edge detection, measurements and saturating next-count values
    always_comb begin
        hs_edge_s    = ~i_hs & hs_q_r;
        vs_edge_s    = ~i_vs & vs_q_r;
        line_meas_s  = h_cnt_r + 10'd1;
        frame_meas_s = v_cnt_r + {9'd0, hs_edge_s};
        h_nxt_s      = h_cnt_r;
        v_nxt_s      = v_cnt_r;
        if (hs_edge_s) begin
            h_nxt_s = 10'd0;
        end else if (h_cnt_r != CNT_MAX) begin
            h_nxt_s = line_meas_s;
        end else begin
            h_nxt_s = CNT_MAX;
        end
        // A vs edge restarts the frame even when an hs edge lands on the same strobe
        if (vs_edge_s) begin
            v_nxt_s = 10'd0;
        end else if (hs_edge_s && (v_cnt_r != CNT_MAX)) begin
            v_nxt_s = v_cnt_r + 10'd1;
        end else begin
            v_nxt_s = v_cnt_r;
        end
    end

    // Violation detection and the lock/active view after this strobe
    always_comb begin
        viol_s = (hs_edge_s && (line_meas_s != LINE_W))
               || (vs_edge_s && (frame_meas_s != SCREEN_W))
               || (h_nxt_s == CNT_MAX) || (v_nxt_s == CNT_MAX);
        frame_ok_s   = ~frame_bad_r & ~viol_s;
        good_inc_s   = good_r + 2'd1;
        locked_nxt_s = 1'b0;
        case (state_r)
            SEARCH:  locked_nxt_s = 1'b0;
            MEASURE: locked_nxt_s = vs_edge_s && frame_ok_s && (good_inc_s == LOCK_W);
            LOCKED:  locked_nxt_s = ~viol_s;
            default: locked_nxt_s = 1'b0;
        endcase
        active_nxt_s = locked_nxt_s
                     && (h_nxt_s >= H_LO) && (h_nxt_s < H_HI)
                     && (v_nxt_s >= V_LO) && (v_nxt_s < V_HI);
        x_nxt_s  = h_nxt_s - H_LO;
        y_full_s = v_nxt_s - V_LO;
    end

    // Counters, lock FSM and registered outputs; everything advances on strobes only
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r       <= SEARCH;
            good_r        <= 2'd0;
            frame_bad_r   <= 1'b0;
            hs_q_r        <= 1'b1;
            vs_q_r        <= 1'b1;
            h_cnt_r       <= 10'd0;
            v_cnt_r       <= 10'd0;
            o_x           <= 10'd0;
            o_y           <= 9'd0;
            o_active      <= 1'b0;
            o_locked      <= 1'b0;
            o_frame_start <= 1'b0;
            o_err         <= 1'b0;
            o_line_len    <= 10'd0;
            o_frame_lines <= 10'd0;
        end else begin
            o_frame_start <= 1'b0;
            o_err         <= 1'b0;
            if (i_pix_stb) begin
                hs_q_r        <= i_hs;
                vs_q_r        <= i_vs;
                h_cnt_r       <= h_nxt_s;
                v_cnt_r       <= v_nxt_s;
                o_frame_start <= vs_edge_s;
                o_locked      <= locked_nxt_s;
                o_active      <= active_nxt_s;
                o_x           <= active_nxt_s ? x_nxt_s : 10'd0;
                o_y           <= active_nxt_s ? y_full_s[8:0] : 9'd0;
                if (hs_edge_s) begin
                    o_line_len <= line_meas_s;
                end
                if (vs_edge_s) begin
                    o_frame_lines <= frame_meas_s;
                end
                case (state_r)
                    SEARCH: begin
                        if (vs_edge_s) begin
                            state_r     <= MEASURE;
                            good_r      <= 2'd0;
                            frame_bad_r <= 1'b0;
                        end
                    end
                    MEASURE: begin
                        // frame_bad_r remembers a violation earlier in the frame being closed
                        if (vs_edge_s) begin
                            frame_bad_r <= 1'b0;
                            if (!frame_ok_s) begin
                                good_r <= 2'd0;
                            end else if (good_inc_s == LOCK_W) begin
                                good_r  <= good_inc_s;
                                state_r <= LOCKED;
                            end else begin
                                good_r <= good_inc_s;
                            end
                        end else if (viol_s) begin
                            good_r      <= 2'd0;
                            frame_bad_r <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (viol_s) begin
                            o_err   <= 1'b1;
                            state_r <= SEARCH;
                            good_r  <= 2'd0;
                        end
                    end
                    default: begin
                        state_r <= SEARCH;
                        good_r  <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down raster (20x12) so that many
// frames fit in a short run; every clock is checked against a timestamp model.
module tb_vga_sync_decoder;

    localparam int LINE        = 20;
    localparam int SCREEN      = 12;
    localparam int H_OFS       = 4;
    localparam int V_OFS       = 2;
    localparam int H_ACT       = 12;
    localparam int V_ACT       = 8;
    localparam int LOCK_FRAMES = 2;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_pix_stb;
    logic       i_hs;
    logic       i_vs;
    logic [9:0] o_x;
    logic [8:0] o_y;
    logic       o_active;
    logic       o_locked;
    logic       o_frame_start;
    logic       o_err;
    logic [9:0] o_line_len;
    logic [9:0] o_frame_lines;

    vga_sync_decoder #(
        .LINE(LINE), .SCREEN(SCREEN), .H_OFS(H_OFS), .V_OFS(V_OFS),
        .H_ACT(H_ACT), .V_ACT(V_ACT), .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_hs(i_hs), .i_vs(i_vs),
        .o_x(o_x), .o_y(o_y), .o_active(o_active), .o_locked(o_locked),
        .o_frame_start(o_frame_start), .o_err(o_err),
        .o_line_len(o_line_len), .o_frame_lines(o_frame_lines)
    );

    always #5 i_clk = ~i_clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: positions are time differences since the last sync edges
    int m_idx, m_h_org, m_lines, m_mode, m_good;
    bit m_bad, m_phs, m_pvs;
    int e_line_len, e_frame_lines, e_h, e_v;
    bit e_fs, e_err;
    int vs_edges = 0;

    // Bench bookkeeping
    bit cur_hs = 1'b1, cur_vs = 1'b1, rand_gap = 1'b0, act_en = 1'b0;
    int err_cnt = 0, err_line_len = -1, lock_at = -1, mark_edges = 0;
    int act_cnt, min_x, max_x, min_y, max_y;

    function automatic int sat(input int v);
        return (v > 1023) ? 1023 : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit stb, input bit hs, input bit vs);
        bit hf, vf, viol;
        int h_old, v_old;
        e_fs  = 1'b0;
        e_err = 1'b0;
        if (rst) begin
            m_idx = 0; m_h_org = 0; m_lines = 0; m_mode = 0; m_good = 0;
            m_bad = 1'b0; m_phs = 1'b1; m_pvs = 1'b1;
            e_line_len = 0; e_frame_lines = 0; e_h = 0; e_v = 0;
        end else if (stb) begin
            hf = m_phs && !hs;
            vf = m_pvs && !vs;
            m_phs = hs;
            m_pvs = vs;
            h_old = sat(m_idx - m_h_org);
            v_old = sat(m_lines);
            m_idx++;
            viol = 1'b0;
            if (hf) begin
                e_line_len = (h_old + 1) % 1024;
                m_h_org = m_idx;
                if (e_line_len != LINE) viol = 1'b1;
            end
            if (vf) begin
                e_frame_lines = (v_old + int'(hf)) % 1024;
                m_lines = 0;
                if (e_frame_lines != SCREEN) viol = 1'b1;
                e_fs = 1'b1;
                vs_edges++;
            end else if (hf) begin
                m_lines++;
            end
            e_h = sat(m_idx - m_h_org);
            e_v = sat(m_lines);
            if (e_h == 1023 || e_v == 1023) viol = 1'b1;
            if (m_mode == 0) begin
                if (vf) begin m_mode = 1; m_good = 0; m_bad = 1'b0; end
            end else if (m_mode == 1) begin
                if (vf) begin
                    m_good = (m_bad || viol) ? 0 : m_good + 1;
                    m_bad = 1'b0;
                    if (m_good >= LOCK_FRAMES) m_mode = 2;
                end else if (viol) begin
                    m_good = 0;
                    m_bad = 1'b1;
                end
            end else if (viol) begin
                e_err = 1'b1;
                m_mode = 0;
            end
        end
    endtask

    task automatic compare_model();
        bit e_act;
        int e_x, e_y;
        e_act = (m_mode == 2) && e_h >= H_OFS && e_h < H_OFS + H_ACT
                && e_v >= V_OFS && e_v < V_OFS + V_ACT;
        e_x = e_act ? e_h - H_OFS : 0;
        e_y = e_act ? e_v - V_OFS : 0;
        vectors++;
        if (o_x !== 10'(e_x) || o_y !== 9'(e_y) || o_active !== e_act
            || o_locked !== (m_mode == 2) || o_frame_start !== e_fs || o_err !== e_err
            || o_line_len !== 10'(e_line_len) || o_frame_lines !== 10'(e_frame_lines)) begin
            miscompares++;
            $display("FAIL model t=%0t got x=%0d y=%0d act=%0b lock=%0b fs=%0b err=%0b ll=%0d fl=%0d, expected x=%0d y=%0d act=%0b lock=%0b fs=%0b err=%0b ll=%0d fl=%0d",
                     $time, o_x, o_y, o_active, o_locked, o_frame_start, o_err, o_line_len, o_frame_lines,
                     e_x, e_y, e_act, (m_mode == 2), e_fs, e_err, e_line_len, e_frame_lines);
        end
    endtask

    task automatic tick(input bit rst, input bit stb, input bit hs, input bit vs);
        i_rst = rst; i_pix_stb = stb; i_hs = hs; i_vs = vs;
        @(posedge i_clk);
        model_step(rst, stb, hs, vs);
        @(negedge i_clk);
        compare_model();
        if (o_err) begin
            err_cnt++;
            err_line_len = int'(o_line_len);
        end
        if (lock_at < 0 && o_locked) lock_at = vs_edges - mark_edges;
    endtask

    task automatic mark();
        mark_edges = vs_edges;
        lock_at = -1;
    endtask

    task automatic strobe(input bit hs, input bit vs);
        int idle;
        idle = rand_gap ? int'($urandom_range(0, 3)) : 3;
        for (int k = 0; k < idle; k++) tick(1'b0, 1'b0, cur_hs, cur_vs);
        cur_hs = hs;
        cur_vs = vs;
        tick(1'b0, 1'b1, hs, vs);
        if (act_en && o_active) begin
            act_cnt++;
            if (int'(o_x) < min_x) min_x = int'(o_x);
            if (int'(o_x) > max_x) max_x = int'(o_x);
            if (int'(o_y) < min_y) min_y = int'(o_y);
            if (int'(o_y) > max_y) max_y = int'(o_y);
        end
    endtask

    // One source frame; hs low for 3 strobes per line, vs low for 2 lines
    task automatic send_frame(input int short_line, input int vs_mid, input int rst_line, input int hold_line);
        int len;
        bit hs, vs;
        for (int l = 0; l < SCREEN; l++) begin
            len = (l == short_line) ? LINE - 1 : LINE;
            for (int c = 0; c < len; c++) begin
                hs = (c >= 3);
                if (vs_mid != 0) vs = !((l == 0 && c >= LINE / 2) || l == 1 || (l == 2 && c < LINE / 2));
                else vs = (l >= 2);
                if (l == rst_line && c == 8) begin
                    tick(1'b1, 1'b0, cur_hs, cur_vs);
                    check("rst_xy", int'({o_x, o_y}), 0);
                    check("rst_flags", int'({o_active, o_locked, o_frame_start, o_err}), 0);
                    check("rst_meas", int'({o_line_len, o_frame_lines}), 0);
                    mark();
                end
                if (l == hold_line && c == 8) begin
                    for (int k = 0; k < 50; k++)
                        tick(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    check("hold_xy", int'({o_x, o_y}), ((7 - H_OFS) << 9) | (hold_line - V_OFS));
                    check("hold_lock_act", int'({o_locked, o_active}), 3);
                    check("hold_line_len", int'(o_line_len), LINE);
                end
                strobe(hs, vs);
            end
        end
    endtask

    typedef struct {
        bit         rst, stb, hs, vs;
        logic [9:0] line_len, frame_lines;
        bit         fs;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 10'd3, 10'd0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10'd3, 10'd1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'd3, 10'd1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 10'd3, 10'd1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10'd3, 10'd1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10'd3, 10'd1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 10'd1, 10'd1, 1'b1};
        i_rst = 1'b1; i_pix_stb = 1'b0; i_hs = 1'b1; i_vs = 1'b1;

        for (int i = 0; i < 12; i++) begin
            tick(tbl[i].rst, tbl[i].stb, tbl[i].hs, tbl[i].vs);
            check($sformatf("tbl%0d_line_len", i), int'(o_line_len), int'(tbl[i].line_len));
            check($sformatf("tbl%0d_frame_lines", i), int'(o_frame_lines), int'(tbl[i].frame_lines));
            check($sformatf("tbl%0d_fs_err_lock", i), int'({o_frame_start, o_err, o_locked}), int'(tbl[i].fs) << 2);
        end

        // Nominal source from reset: lock, measurements and active window
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        cur_hs = 1'b1; cur_vs = 1'b1;
        mark();
        err_cnt = 0;
        for (int f = 0; f < 4; f++) begin
            act_en = (f == 3);
            act_cnt = 0; min_x = 1 << 30; max_x = -1; min_y = 1 << 30; max_y = -1;
            send_frame(-1, 0, -1, -1);
        end
        act_en = 1'b0;
        check("lock_edge_nominal", lock_at, 3);
        check("line_len_nominal", int'(o_line_len), LINE);
        check("frame_lines_nominal", int'(o_frame_lines), SCREEN);
        check("active_count", act_cnt, H_ACT * V_ACT);
        check("x_min", min_x, 0);
        check("x_max", max_x, H_ACT - 1);
        check("y_min", min_y, 0);
        check("y_max", max_y, V_ACT - 1);
        check("err_nominal", err_cnt, 0);

        // One short line while locked
        err_cnt = 0;
        send_frame(5, 0, -1, -1);
        check("short_err_pulses", err_cnt, 1);
        check("short_line_len", err_line_len, LINE - 1);
        check("short_unlocked", int'(o_locked), 0);
        mark();
        for (int f = 0; f < 3; f++) send_frame(-1, 0, -1, -1);
        check("lock_edge_after_short", lock_at, 3);

        // hs stuck high long enough to saturate the line counter
        err_cnt = 0;
        for (int k = 0; k < 1100; k++) strobe(1'b1, 1'b1);
        check("stuck_err_pulses", err_cnt, 1);
        check("stuck_unlocked", int'(o_locked), 0);
        mark();
        for (int f = 0; f < 3; f++) send_frame(-1, 0, -1, -1);
        check("lock_edge_after_stuck", lock_at, 3);

        // vs at mid-line versus vs coincident with hs
        err_cnt = 0;
        send_frame(-1, 1, -1, -1);
        check("mid_frame_lines", int'(o_frame_lines), SCREEN);
        send_frame(-1, 1, -1, -1);
        send_frame(-1, 0, -1, -1);
        check("coincident_frame_lines", int'(o_frame_lines), SCREEN);
        check("vs_phase_err", err_cnt, 0);
        check("vs_phase_locked", int'(o_locked), 1);

        // Strobe stall mid-line, then reset mid-frame while locked
        send_frame(-1, 0, -1, 5);
        send_frame(-1, 0, 5, -1);
        for (int f = 0; f < 3; f++) send_frame(-1, 0, -1, -1);
        check("lock_edge_after_reset", lock_at, 3);

        // Random strobe spacing and sync noise, then recovery
        rand_gap = 1'b1;
        for (int k = 0; k < 400; k++)
            tick(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 15) != 0));
        cur_hs = i_hs; cur_vs = i_vs;
        for (int f = 0; f < 4; f++) send_frame(-1, 0, -1, -1);
        check("relock_after_noise", int'(o_locked), 1);
        rand_gap = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
